// File: rtl/sd_bidir_pio.sv
// Avalon-MM PIO for bidirectional SD pads: per-bit direction, input synchronisers, edge capture, masked irq.
// Define SD_PIO_BITSET_EN to map atomic data_out set (addr 4) and clear (addr 5).
module sd_bidir_pio #(
    parameter int unsigned     WIDTH       = 4,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter int unsigned     EDGE_TYPE   = 2,
    parameter logic [WIDTH-1:0] RESET_DIR  = '0,
    parameter logic [WIDTH-1:0] RESET_OUT  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    inout  wire  [WIDTH-1:0]  bidir_port
);

    localparam int unsigned ARM_CNT = SYNC_STAGES + 1;
    localparam int unsigned CNT_W   = 3;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] pad_s;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic [CNT_W-1:0] arm_cnt;
    logic             armed;
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign armed     = (arm_cnt == CNT_W'(ARM_CNT));

    // Per-bit tristate pad drivers
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
    end

    // Input synchroniser; zero stages passes the raw pad straight through
    if (SYNC_STAGES == 0) begin : g_nosync
        assign pad_s = bidir_port;
    end else begin : g_sync
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            end else begin
                sync_q[0] <= bidir_port;
                for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
        end

        assign pad_s = sync_q[SYNC_STAGES-1];
    end

    // Edge detect, held off until prev and the sync chain hold real pad data
    always_comb begin
        edge_det = pad_s ^ prev;
        if (EDGE_TYPE == 0) begin
            edge_det = pad_s & ~prev;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~pad_s & prev;
        end
        if (!armed) begin
            edge_det = '0;
        end
    end

    always_comb begin
        cap_clr = '0;
        if (wr_en && (address == 3'd3)) begin
            cap_clr = wd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= '0;
            prev    <= '0;
        end else begin
            if (!armed) begin
                arm_cnt <= arm_cnt + CNT_W'(1);
            end
            prev <= pad_s;
        end
    end

    // Register file; a new edge beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_OUT;
            dir      <= RESET_DIR;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | edge_det;
            if (wr_en) begin
                case (address)
                    3'd0:    data_out <= wd;
                    3'd1:    dir      <= wd;
                    3'd2:    irq_mask <= wd;
`ifdef SD_PIO_BITSET_EN
                    3'd4:    data_out <= data_out | wd;
                    3'd5:    data_out <= data_out & ~wd;
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = 32'(pad_s);
            3'd1:    rd_mux = 32'(dir);
            3'd2:    rd_mux = 32'(irq_mask);
            3'd3:    rd_mux = 32'(edge_cap);
`ifdef SD_PIO_BITSET_EN
            3'd4:    rd_mux = 32'(data_out);
            3'd5:    rd_mux = 32'(data_out);
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_sd_bidir_pio.sv
// Directed bench for sd_bidir_pio (default parameters): register table plus multi-cycle pad/edge/reset sequences.
module tb_sd_bidir_pio;

    localparam int unsigned W = 4;

`ifdef SD_PIO_BITSET_EN
    localparam logic [W-1:0]  EXP_SET  = 4'hF;
    localparam logic [W-1:0]  EXP_CLR  = 4'hC;
    localparam logic [31:0]   EXP_RD4  = 32'hC;
`else
    localparam logic [W-1:0]  EXP_SET  = 4'h5;
    localparam logic [W-1:0]  EXP_CLR  = 4'h5;
    localparam logic [31:0]   EXP_RD4  = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    wire  [W-1:0] pads;
    logic        ext_en;
    logic [W-1:0] ext_drv;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    assign pads = ext_en ? ext_drv : {W{1'bz}};

    always #5 clk = ~clk;

    sd_bidir_pio #(
        .WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_DIR(4'h0), .RESET_OUT(4'h0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .bidir_port(pads)
    );

    typedef struct {
        logic [2:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle starting just after a falling edge, ending on the next falling edge
    task automatic bus(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        bus(a, 1'b1, 1'b0, wd);
    endtask

    task automatic rd(input logic [2:0] a);
        bus(a, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        tbl[0]  = '{3'd2, 1'b1, 1'b0, 32'hFFFF_FFF5, 1'b0, 32'h0};
        tbl[1]  = '{3'd2, 1'b0, 1'b1, 32'h0,         1'b1, 32'h5};
        tbl[2]  = '{3'd2, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[3]  = '{3'd2, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
        tbl[4]  = '{3'd1, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
        tbl[5]  = '{3'd6, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0};
        tbl[6]  = '{3'd6, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
        tbl[7]  = '{3'd7, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
        tbl[8]  = '{3'd2, 1'b0, 1'b0, 32'h7,         1'b0, 32'h0};
        tbl[9]  = '{3'd2, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
        tbl[10] = '{3'd2, 1'b1, 1'b1, 32'h7,         1'b0, 32'h0};
        tbl[11] = '{3'd2, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
        tbl[12] = '{3'd0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h3};

        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        ext_en     = 1'b1;
        ext_drv    = 4'hA;

        // Reset state and synchronised pad read
        idle(2);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_pads_float", 32'(pads), 32'hA);
        reset_n = 1'b1;
        idle(2);
        chk("sync_latency_2", readdata, 32'h0);
        idle(1);
        chk("sync_latency_3", readdata, 32'hA);
        idle(3);
        rd(3'd3);
        chk("arm_no_edge", readdata, 32'h0);
        chk("arm_irq", 32'(irq), 32'h0);

        // Output drive and release
        ext_drv = 4'h5;
        idle(4);
        wr(3'd0, 32'h5);
        wr(3'd1, 32'hF);
        ext_en = 1'b0;
        #1;
        chk("pads_drive", 32'(pads), 32'h5);
        idle(3);
        rd(3'd0);
        chk("drive_readback", readdata, 32'h5);
        wr(3'd3, 32'hF);
        rd(3'd3);
        chk("cap_clear_all", readdata, 32'h0);
        wr(3'd1, 32'h0);
        ext_drv = 4'hA;
        ext_en  = 1'b1;
        #1;
        chk("pads_release", 32'(pads), 32'hA);
        idle(3);
        rd(3'd0);
        chk("release_readback", readdata, 32'hA);

        // Masked rise on bit1 raises irq after sync latency, clear drops it
        ext_drv = 4'h0;
        idle(4);
        wr(3'd3, 32'hF);
        wr(3'd2, 32'h2);
        rd(3'd3);
        chk("pre_rise_cap", readdata, 32'h0);
        chk("pre_rise_irq", 32'(irq), 32'h0);
        ext_drv = 4'h2;
        idle(2);
        chk("rise_irq_early", 32'(irq), 32'h0);
        idle(1);
        chk("rise_irq", 32'(irq), 32'h1);
        rd(3'd3);
        chk("rise_cap", readdata, 32'h2);
        wr(3'd3, 32'h2);
        chk("clr_irq", 32'(irq), 32'h0);
        rd(3'd3);
        chk("clr_cap", readdata, 32'h0);

        // Set wins over a simultaneous clear; a pulse leaves the bit set
        ext_drv = 4'h3;
        idle(2);
        wr(3'd3, 32'h1);
        rd(3'd3);
        chk("set_beats_clr", readdata, 32'h1);
        chk("unmasked_irq", 32'(irq), 32'h0);
        wr(3'd3, 32'h1);
        rd(3'd3);
        chk("clr_bit0", readdata, 32'h0);
        ext_drv = 4'h2;
        idle(1);
        ext_drv = 4'h3;
        idle(4);
        rd(3'd3);
        chk("pulse_cap", readdata, 32'h1);
        wr(3'd3, 32'h1);
        rd(3'd3);
        chk("pulse_clr", readdata, 32'h0);

        // Register access table
        for (int i = 0; i < 13; i++) begin
            bus(tbl[i].a, tbl[i].cs, tbl[i].wn, tbl[i].wd);
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
                chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'h0);
            end
        end

        // Atomic set/clear (or ignored writes when not built in)
        wr(3'd1, 32'hF);
        ext_en = 1'b0;
        #1;
        chk("bs_base", 32'(pads), 32'h5);
        wr(3'd4, 32'hA);
        #1;
        chk("bs_set", 32'(pads), 32'(EXP_SET));
        wr(3'd5, 32'h3);
        #1;
        chk("bs_clr", 32'(pads), 32'(EXP_CLR));
        rd(3'd4);
        chk("bs_rd4", readdata, EXP_RD4);

        // Asynchronous reset in mid-cycle with irq pending and pads driven
        idle(4);
        wr(3'd2, 32'hF);
        chk("pre_reset_irq", 32'(irq), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_irq", 32'(irq), 32'h0);
        chk("async_readdata", readdata, 32'h0);
        ext_drv = 4'hA;
        ext_en  = 1'b1;
        #1;
        chk("async_pads_float", 32'(pads), 32'hA);
        @(negedge clk);
        reset_n = 1'b1;
        idle(5);
        rd(3'd0);
        chk("post_rst_pad", readdata, 32'hA);
        rd(3'd1);
        chk("post_rst_dir", readdata, 32'h0);
        rd(3'd2);
        chk("post_rst_mask", readdata, 32'h0);
        rd(3'd3);
        chk("post_rst_cap", readdata, 32'h0);
        rd(3'd4);
        chk("post_rst_dout", readdata, 32'h0);
        chk("post_rst_irq", 32'(irq), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
